// File: rtl/dlx_pkg.sv
// Shared constants and types for the DLX data-memory dump unit.
// Holds the halt trap encoding, the dump FSM state type and the byte-packing helper.
package dlx_pkg;

  localparam logic [31:0] HALT_TRAP = 32'h4400_0300;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StSend  = 2'd2,
    StDone  = 2'd3
  } dump_state_e;

  // Shift a new byte in at the bottom so the first byte ends up in bits 31:24.
  function automatic logic [31:0] pack_be(input logic [31:0] word, input logic [7:0] b);
    return {word[23:0], b};
  endfunction

endpackage

// File: rtl/dmem_dump_unit_if.sv
// Word stream from the dump unit to a host or UART bridge.
// The master drives dout/dout_valid/dout_last; the slave drives dout_ready.
interface dmem_dump_unit_if;

  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_last;

  modport master (
    output dout,
    output dout_valid,
    output dout_last,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_valid,
    input  dout_last,
    output dout_ready
  );

endinterface

// File: rtl/dump_word_packer.sv
// Four-byte big-endian shift register with a 2-bit byte counter.
// full is high on the edge whose load completes a word, so the caller can leave FETCH on time.
module dump_word_packer
  import dlx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        full
);

  logic [31:0] word_q;
  logic [1:0]  cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (load_en) begin
      word_q <= pack_be(word_q, byte_in);
      cnt_q  <= cnt_q + 2'd1;
    end
  end

  assign word = word_q;
  assign full = load_en && (cnt_q == 2'd3);

endmodule

// File: rtl/dmem_dump_unit.sv
// Streams DMEM out as big-endian 32-bit words once the core hits the halt trap or start pulses.
// Freezes the core via halt and owns the DMEM read address for the rest of the run.
module dmem_dump_unit
  import dlx_pkg::*;
#(
  parameter int unsigned SIZE       = 1024,
  parameter int unsigned ADDR_W     = 10,
  parameter logic [31:0] HALT_INSTR = HALT_TRAP
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         instruction,
  input  logic                start,
  output logic                halt,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [7:0]          mem_rdata,
  dmem_dump_unit_if.master    dout_if,
  output logic                busy,
  output logic                done
);

  localparam int unsigned         WordW    = ADDR_W - 2;
  localparam logic [WordW-1:0]    LastWord = WordW'(SIZE / 4 - 1);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WordW-1:0]  wcnt_q, wcnt_d;
  logic              load_en;
  logic              word_full;
  logic [31:0]       word;
  logic              trigger;
  logic              is_last;

  assign trigger = (instruction == HALT_INSTR) | start;
  assign is_last = (wcnt_q == LastWord);

  dump_word_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .load_en (load_en),
    .byte_in (mem_rdata),
    .word    (word),
    .full    (word_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    load_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          state_d = StFetch;
          addr_d  = '0;
          wcnt_d  = '0;
        end
      end
      StFetch: begin
        load_en = 1'b1;
        addr_d  = addr_q + ADDR_W'(1);
        if (word_full) state_d = StSend;
      end
      StSend: begin
        // dout_ready only steers the next state; valid/data come from registers.
        if (dout_if.dout_ready) begin
          wcnt_d  = wcnt_q + WordW'(1);
          state_d = is_last ? StDone : StFetch;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  assign halt               = (state_q != StIdle);
  assign busy               = (state_q == StFetch) || (state_q == StSend);
  assign done               = (state_q == StDone);
  assign mem_addr           = addr_q;
  assign dout_if.dout       = word;
  assign dout_if.dout_valid = (state_q == StSend);
  assign dout_if.dout_last  = (state_q == StSend) && is_last;

endmodule

// File: tb/tb_dmem_dump_unit.sv
// Self-checking bench for dmem_dump_unit on a 16-byte DMEM holding DMEM[i] = i.
module tb_dmem_dump_unit;
  import dlx_pkg::*;

  localparam int unsigned SIZE   = 16;
  localparam int unsigned ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [31:0]       instruction;
  logic              halt, busy, done;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic [7:0]        mem [SIZE];

  dmem_dump_unit_if dif();

  dmem_dump_unit #(
    .SIZE       (SIZE),
    .ADDR_W     (ADDR_W),
    .HALT_INSTR (HALT_TRAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .start       (start),
    .halt        (halt),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .dout_if     (dif),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr];

  typedef struct {
    logic [31:0] word;
    logic        last;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        st;
    logic        dump;
  } vec_t;
  vec_t vecs[5];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Scoreboard: every accepted word must match the head of the expected queue.
  always @(posedge clk) begin
    if (!rst && dif.dout_valid && dif.dout_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_word: got %h expected no word", dif.dout);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("word", dif.dout, e.word);
        check("last", {31'b0, dif.dout_last}, {31'b0, e.last});
      end
    end
  end

  task automatic push_words();
    for (int w = 0; w < 4; w++) begin
      exp_t e;
      e.word = {8'(4 * w), 8'(4 * w + 1), 8'(4 * w + 2), 8'(4 * w + 3)};
      e.last = (w == 3);
      exp_q.push_back(e);
    end
  endtask

  // Caller is at a negedge.
  task automatic do_reset();
    rst            = 1'b1;
    start          = 1'b0;
    instruction    = 32'h0;
    dif.dout_ready = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("rst_halt", {31'b0, halt}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_valid", {31'b0, dif.dout_valid}, 32'd0);
    check("rst_last", {31'b0, dif.dout_last}, 32'd0);
    check("rst_addr", {28'b0, mem_addr}, 32'd0);
    check("rst_dout", dif.dout, 32'd0);
    rst = 1'b0;
  endtask

  task automatic fire(input logic [31:0] instr, input logic st);
    instruction = instr;
    start       = st;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name, output int k);
    k = 0;
    while (!dif.dout_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!dif.dout_valid) begin
      total++;
      bad++;
      $display("FAIL %s: got no valid expected valid", name);
    end
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 200 && !done; i++) @(negedge clk);
    check(name, {31'b0, done}, 32'd1);
    check({name, "_halt"}, {31'b0, halt}, 32'd1);
    check({name, "_busy"}, {31'b0, busy}, 32'd0);
    check({name, "_valid"}, {31'b0, dif.dout_valid}, 32'd0);
    check({name, "_drained"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    int k;
    for (int i = 0; i < SIZE; i++) mem[i] = 8'(i);
    vecs[0] = '{"trap",           32'h4400_0300, 1'b0, 1'b1};
    vecs[1] = '{"start",          32'h4400_0301, 1'b1, 1'b1};
    vecs[2] = '{"near_miss",      32'h4400_0301, 1'b0, 1'b0};
    vecs[3] = '{"trap_and_start", 32'h4400_0300, 1'b1, 1'b1};
    vecs[4] = '{"idle_zero",      32'h0000_0000, 1'b0, 1'b0};

    @(negedge clk);
    for (int v = 0; v < 5; v++) begin
      do_reset();
      if (vecs[v].dump) push_words();
      fire(vecs[v].instr, vecs[v].st);
      check({vecs[v].name, "_halt"}, {31'b0, halt}, {31'b0, vecs[v].dump});
      if (vecs[v].dump) begin
        check({vecs[v].name, "_busy"}, {31'b0, busy}, 32'd1);
        check({vecs[v].name, "_addr0"}, {28'b0, mem_addr}, 32'd0);
        wait_valid(vecs[v].name, k);
        check({vecs[v].name, "_latency"}, k, 32'd4);
        wait_done({vecs[v].name, "_done"});
      end else begin
        repeat (10) @(negedge clk);
        check({vecs[v].name, "_idle_halt"}, {31'b0, halt}, 32'd0);
        check({vecs[v].name, "_idle_busy"}, {31'b0, busy}, 32'd0);
        check({vecs[v].name, "_idle_valid"}, {31'b0, dif.dout_valid}, 32'd0);
      end
    end

    // Backpressure on the second word.
    do_reset();
    dif.dout_ready = 1'b0;
    push_words();
    fire(HALT_TRAP, 1'b0);
    wait_valid("bp_w0", k);
    dif.dout_ready = 1'b1;
    @(negedge clk);
    dif.dout_ready = 1'b0;
    wait_valid("bp_w1", k);
    for (int i = 0; i < 3; i++) begin
      check("bp_dout", dif.dout, 32'h0405_0607);
      check("bp_addr", {28'b0, mem_addr}, 32'd8);
      check("bp_valid", {31'b0, dif.dout_valid}, 32'd1);
      @(negedge clk);
    end
    dif.dout_ready = 1'b1;
    wait_done("bp_done");

    // Start pulse while a word is waiting in SEND.
    do_reset();
    dif.dout_ready = 1'b0;
    push_words();
    fire(32'h0, 1'b1);
    wait_valid("ss_w0", k);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ss_valid", {31'b0, dif.dout_valid}, 32'd1);
    check("ss_addr", {28'b0, mem_addr}, 32'd4);
    check("ss_dout", dif.dout, 32'h0001_0203);
    dif.dout_ready = 1'b1;
    wait_done("ss_done");
    repeat (10) @(negedge clk);
    check("ss_done_hold", {31'b0, done}, 32'd1);

    // Reset after the second word is accepted, then restart.
    do_reset();
    push_words();
    fire(HALT_TRAP, 1'b0);
    for (int i = 0; i < 100 && exp_q.size() != 2; i++) @(negedge clk);
    check("mid_two_taken", exp_q.size(), 32'd2);
    do_reset();
    push_words();
    fire(HALT_TRAP, 1'b0);
    wait_valid("mid_restart", k);
    check("mid_restart_dout", dif.dout, 32'h0001_0203);
    wait_done("mid_done");

    // Trap held after DONE must not restart the dump.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("sticky_done", {31'b0, done}, 32'd1);
      check("sticky_valid", {31'b0, dif.dout_valid}, 32'd0);
      check("sticky_busy", {31'b0, busy}, 32'd0);
      check("sticky_halt", {31'b0, halt}, 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
